// File: rtl/exec_init_loader.sv
// exec_init_loader: collects 48-bit initial values for registers A, B and C
// from a byte stream, then shifts them MSB-first onto the execute stage's
// serial init lines while init_regs is high, and finally pulses load_done.
//
// Optional build macro EXEC_INIT_LOADER_CHECKSUM_EN: the 18 data bytes are
// followed by one XOR checksum byte. A mismatch skips the shift phase and
// sets the sticky load_err flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the first byte of register A
// COLLECT | accepting the remaining data (and checksum) bytes
// SHIFT   | presenting one bit per cycle on the three serial lines
// DONE    | one-cycle completion, load_done pulses after this state
//
// Serial outputs, init_regs and load_done are registered. As a result the
// first serial bit appears one cycle after the last byte is accepted, and
// load_done follows the last shift bit directly.
module exec_init_loader #(
  parameter  int REG_WIDTH = 48,
  localparam int NUM_BYTES = REG_WIDTH / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic       init_regs,
  output logic       A_lsb_opcode_0,
  output logic       B_lsb_opcode_1,
  output logic       C_lsb_opcode_2,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);

  localparam int DATA_BYTES = 3 * NUM_BYTES;
  localparam int CNT_W      = $clog2(DATA_BYTES + 2);
  localparam int SH_W       = $clog2(REG_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [SH_W-1:0]        r_shift_cnt;
  logic [REG_WIDTH-1:0]   r_shadow_a;
  logic [REG_WIDTH-1:0]   r_shadow_b;
  logic [REG_WIDTH-1:0]   r_shadow_c;
  logic                   r_init_regs;
  logic                   r_a_bit;
  logic                   r_b_bit;
  logic                   r_c_bit;
  logic                   r_load_done;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last_byte;
  logic                   w_shifting;

`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
  logic [7:0]             r_csum;
  logic                   r_load_err;
  logic                   w_csum_ok;

  // The checksum byte sits right after the last C byte.
  assign w_last_byte = (r_byte_cnt == CNT_W'(DATA_BYTES));
  assign w_csum_ok   = (in_data == r_csum);
  assign load_err    = r_load_err;
`else
  assign w_last_byte = (r_byte_cnt == CNT_W'(DATA_BYTES - 1));
  assign load_err    = 1'b0;
`endif

  // Abort in SHIFT must drop init_regs on the very next cycle.
  assign w_shifting = (r_state == S_SHIFT) && !abort;

  // Next-state logic and the state-only handshake signals.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    w_accept     = in_valid && w_in_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_accept && w_last_byte) begin
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
          w_next_state = w_csum_ok ? S_SHIFT : S_IDLE;
`else
          w_next_state = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (r_shift_cnt == SH_W'(REG_WIDTH - 1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Byte collection into the shadows and shifting them out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_shift_cnt <= '0;
      r_shadow_a  <= '0;
      r_shadow_b  <= '0;
      r_shadow_c  <= '0;
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
      r_csum      <= '0;
      r_load_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow_a <= {r_shadow_a[REG_WIDTH-9:0], in_data};
            r_byte_cnt <= CNT_W'(1);
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
            r_csum     <= in_data;
            r_load_err <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (abort) begin
            r_byte_cnt <= '0;
            r_shadow_a <= '0;
            r_shadow_b <= '0;
            r_shadow_c <= '0;
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end else if (w_accept) begin
            if (r_byte_cnt < CNT_W'(NUM_BYTES)) begin
              r_shadow_a <= {r_shadow_a[REG_WIDTH-9:0], in_data};
            end else if (r_byte_cnt < CNT_W'(2 * NUM_BYTES)) begin
              r_shadow_b <= {r_shadow_b[REG_WIDTH-9:0], in_data};
            end else if (r_byte_cnt < CNT_W'(DATA_BYTES)) begin
              r_shadow_c <= {r_shadow_c[REG_WIDTH-9:0], in_data};
            end
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_data;
`endif
            if (w_last_byte) begin
              r_byte_cnt  <= '0;
              r_shift_cnt <= '0;
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
              if (!w_csum_ok) begin
                r_load_err <= 1'b1;
                r_shadow_a <= '0;
                r_shadow_b <= '0;
                r_shadow_c <= '0;
              end
`endif
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_shift_cnt <= '0;
            r_shadow_a  <= '0;
            r_shadow_b  <= '0;
            r_shadow_c  <= '0;
          end else begin
            r_shift_cnt <= r_shift_cnt + SH_W'(1);
            r_shadow_a  <= {r_shadow_a[REG_WIDTH-2:0], 1'b0};
            r_shadow_b  <= {r_shadow_b[REG_WIDTH-2:0], 1'b0};
            r_shadow_c  <= {r_shadow_c[REG_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered serial lines, init strobe and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_regs <= 1'b0;
      r_a_bit     <= 1'b0;
      r_b_bit     <= 1'b0;
      r_c_bit     <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_init_regs <= w_shifting;
      r_a_bit     <= w_shifting & r_shadow_a[REG_WIDTH-1];
      r_b_bit     <= w_shifting & r_shadow_b[REG_WIDTH-1];
      r_c_bit     <= w_shifting & r_shadow_c[REG_WIDTH-1];
      r_load_done <= (r_state == S_DONE);
    end
  end

  assign in_ready       = w_in_ready;
  assign busy           = (r_state != S_IDLE);
  assign init_regs      = r_init_regs;
  assign A_lsb_opcode_0 = r_a_bit;
  assign B_lsb_opcode_1 = r_b_bit;
  assign C_lsb_opcode_2 = r_c_bit;
  assign load_done      = r_load_done;

endmodule

// File: tb/tb_exec_init_loader.sv
// Bench for exec_init_loader: randomized byte streams, a queue of expected
// register values, and a monitor that rebuilds A/B/C from the serial lines.
module tb_exec_init_loader;

  localparam int RW = 48;
  localparam int NB = RW / 8;
`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
  localparam int NFULL = 3 * NB + 1;
`else
  localparam int NFULL = 3 * NB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic       init_regs;
  logic       a_bit;
  logic       b_bit;
  logic       c_bit;
  logic       busy;
  logic       load_done;
  logic       load_err;

  exec_init_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .abort          (abort),
    .init_regs      (init_regs),
    .A_lsb_opcode_0 (a_bit),
    .B_lsb_opcode_1 (b_bit),
    .C_lsb_opcode_2 (c_bit),
    .busy           (busy),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic [47:0] c;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_first_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: rebuild the serial words and score them on each load_done.
  logic [47:0] cap_a, cap_b, cap_c;
  int bitcnt = 0;
  int first_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (init_regs === 1'b1) begin
      if (bitcnt == 0) first_cyc = cyc;
      cap_a = {cap_a[46:0], a_bit};
      cap_b = {cap_b[46:0], b_bit};
      cap_c = {cap_c[46:0], c_bit};
      bitcnt++;
    end else begin
      if (load_done === 1'b1) begin
        done_cnt++;
        last_done_cyc  = cyc;
        last_first_cyc = first_cyc;
        if (sb.size() == 0) begin
          check("done_expected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("bit_count", 64'(bitcnt), 64'(RW));
          check("serial_a", {16'h0, cap_a}, {16'h0, e.a});
          check("serial_b", {16'h0, cap_b}, {16'h0, e.b});
          check("serial_c", {16'h0, cap_c}, {16'h0, e.c});
        end
      end
      bitcnt = 0;
    end
  end

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [7:0] out_vec();
    return {in_ready, busy, init_regs, load_done, a_bit, b_bit, c_bit, load_err};
  endfunction

  // mode 0: valid held high, 1: toggled, 2: random. With hold, valid keeps
  // being offered until load_done time and any accept is counted as extra.
  task automatic send_load(input logic [47:0] a, input logic [47:0] b, input logic [47:0] c,
                           input int mode, input int nbytes, input bit hold,
                           input bit bad_cs, output int t_last);
    logic [7:0] bytes [19];
    logic [7:0] cs;
    int idx, guard, extra;
    bit phase, v;
    cs = 8'h00;
    for (int i = 0; i < NB; i++) begin
      bytes[i]        = a[47 - 8*i -: 8];
      bytes[NB + i]   = b[47 - 8*i -: 8];
      bytes[2*NB + i] = c[47 - 8*i -: 8];
    end
    for (int i = 0; i < 3*NB; i++) cs = cs ^ bytes[i];
    bytes[18] = cs ^ {7'b0, bad_cs};
    idx = 0; guard = 0; extra = 0; phase = 1'b0; t_last = 0;
    while (idx < nbytes && guard < 500) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      phase    = !phase;
      in_valid = v;
      in_data  = v ? bytes[idx] : 8'($urandom);
      if (v && in_ready) begin
        t_last = cyc + 1;
        idx++;
      end
    end
    check("bytes_sent", 64'(idx), 64'(nbytes));
    if (hold) begin
      guard = 0;
      while (guard < 200) begin
        @(negedge clk);
        guard++;
        if (cyc >= t_last + RW + 1) break;
        in_valid = (mode == 1) ? phase : 1'b1;
        phase    = !phase;
        in_data  = 8'($urandom);
        if (in_valid && in_ready) extra++;
      end
      in_valid = 1'b0;
      check("extra_accepts", 64'(extra), 64'd0);
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Full load with expectations queued first; latency checked afterwards.
  task automatic do_load(input logic [47:0] a, input logic [47:0] b, input logic [47:0] c,
                         input int mode, input bit hold);
    int d0, t;
    exp_t e;
    d0 = done_cnt;
    e.a = a; e.b = b; e.c = c;
    sb.push_back(e);
    send_load(a, b, c, mode, NFULL, hold, 1'b0, t);
    for (int g = 0; g < 150 && done_cnt == d0; g++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(d0 + 1));
    check("done_latency", 64'(last_done_cyc), 64'(t + RW + 1));
    check("init_latency", 64'(last_first_cyc), 64'(t + 1));
    check("load_err_clear", {63'h0, load_err}, 64'd0);
  endtask

  initial begin
    int t, d0, seen_init;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_held", {56'h0, out_vec()}, 64'h80);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", {56'h0, out_vec()}, 64'h80);
    end

    // directed loads: valid held high, then toggled
    do_load(48'h0000_0000_C0DE, 48'h0123_4567_89AB, 48'hFFFF_FFFF_FFFF, 0, 1'b1);
    do_load(48'h0000_0000_C0DE, 48'h0123_4567_89AB, 48'hFFFF_FFFF_FFFF, 1, 1'b1);

    // abort after 7 bytes, simultaneous byte dropped, then fresh 1/2/3 load
    send_load(rand48(), rand48(), rand48(), 0, 7, 1'b0, 1'b0, t);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_collect_idle", {62'h0, busy, in_ready}, 64'd1);
    do_load(48'd1, 48'd2, 48'd3, 0, 1'b0);

    // abort on the 10th shift cycle
    d0 = done_cnt;
    send_load(rand48(), rand48(), rand48(), 0, NFULL, 1'b0, 1'b0, t);
    while (cyc < t + 9) @(negedge clk);
    check("shift_active", {63'h0, init_regs}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_shift", {61'h0, init_regs, busy, load_done}, 64'd0);
    repeat (60) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));

    // reset on the 20th shift cycle
    send_load(rand48(), rand48(), rand48(), 2, NFULL, 1'b0, 1'b0, t);
    while (cyc < t + 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_shift", {56'h0, out_vec()}, 64'h80);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'(d0));

`ifdef EXEC_INIT_LOADER_CHECKSUM_EN
    // wrong checksum: error flag, no shift, back to IDLE
    send_load(rand48(), rand48(), rand48(), 0, NFULL, 1'b0, 1'b1, t);
    check("csum_err_flag", {62'h0, load_err, in_ready}, 64'd3);
    seen_init = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (init_regs === 1'b1) seen_init++;
    end
    check("csum_err_no_shift", 64'(seen_init), 64'd0);
    check("csum_err_no_done", 64'(done_cnt), 64'(d0));
    check("csum_err_sticky", {63'h0, load_err}, 64'd1);
`else
    seen_init = 0;
`endif

    // randomized loads with random valid patterns
    for (int i = 0; i < 5; i++) begin
      do_load(rand48(), rand48(), rand48(), 2, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
